// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter for a single-port synchronous RAM.
// Each access is one ISSUE cycle (RAM strobed) followed by one RESP cycle (ready pulse).
module ram_arbiter #(
  parameter int AW = 11,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          m0_valid,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [3:0]    m0_wstrb,
  output logic          m0_ready,
  output logic [31:0]   m0_rdata,
  input  logic          m1_valid,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_wstrb,
  output logic          m1_ready,
  output logic [31:0]   m1_rdata,
  output logic          ram_en,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  output logic [3:0]    ram_we,
  input  logic [31:0]   ram_rdata,
  output logic          grant,
  output logic [CW-1:0] conflicts
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t  r_state;
  logic    r_last_grant;

  logic    w_arb_valid;
  logic    w_arb_pick;
  logic    w_arb_conflict;
  logic    w_conflicts_sat;

  // In RESP the just-served requester is ignored, so only the other side can win.
  always_comb begin
    w_arb_valid    = 1'b0;
    w_arb_pick     = 1'b0;
    w_arb_conflict = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_arb_valid    = m0_valid | m1_valid;
        w_arb_conflict = m0_valid & m1_valid;
        if (w_arb_conflict) begin
          w_arb_pick = ~r_last_grant;
        end else begin
          w_arb_pick = m1_valid;
        end
      end
      ST_RESP: begin
        w_arb_pick = ~grant;
        if (grant) begin
          w_arb_valid    = m0_valid;
          w_arb_conflict = m0_valid & m1_valid;
        end else begin
          w_arb_valid    = m1_valid;
          w_arb_conflict = m1_valid & m0_valid;
        end
      end
      default: begin
        w_arb_valid    = 1'b0;
        w_arb_pick     = 1'b0;
        w_arb_conflict = 1'b0;
      end
    endcase
  end

  assign w_conflicts_sat = &conflicts;

  // Read data is steered straight from the RAM during the ready cycle and zeroed otherwise.
  assign m0_rdata = m0_ready ? ram_rdata : 32'h0000_0000;
  assign m1_rdata = m1_ready ? ram_rdata : 32'h0000_0000;

  // Arbitration FSM with registered grant, ready and RAM command outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      grant        <= 1'b0;
      conflicts    <= '0;
      m0_ready     <= 1'b0;
      m1_ready     <= 1'b0;
      ram_en       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= 32'h0000_0000;
      ram_we       <= 4'h0;
    end else begin
      case (r_state)
        ST_ISSUE: begin
          r_state   <= ST_RESP;
          ram_en    <= 1'b0;
          ram_addr  <= '0;
          ram_wdata <= 32'h0000_0000;
          ram_we    <= 4'h0;
          m0_ready  <= ~grant;
          m1_ready  <= grant;
        end
        ST_IDLE, ST_RESP: begin
          m0_ready <= 1'b0;
          m1_ready <= 1'b0;
          if (w_arb_conflict && !w_conflicts_sat) begin
            conflicts <= conflicts + {{(CW-1){1'b0}}, 1'b1};
          end
          if (w_arb_valid) begin
            r_state      <= ST_ISSUE;
            grant        <= w_arb_pick;
            r_last_grant <= w_arb_pick;
            ram_en       <= 1'b1;
            ram_addr     <= w_arb_pick ? m1_addr  : m0_addr;
            ram_wdata    <= w_arb_pick ? m1_wdata : m0_wdata;
            ram_we       <= w_arb_pick ? m1_wstrb : m0_wstrb;
          end else begin
            r_state   <= ST_IDLE;
            ram_en    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= 32'h0000_0000;
            ram_we    <= 4'h0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          m0_ready  <= 1'b0;
          m1_ready  <= 1'b0;
          ram_en    <= 1'b0;
          ram_addr  <= '0;
          ram_wdata <= 32'h0000_0000;
          ram_we    <= 4'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: vector table of single-requester accesses plus
// hand-written contention, reset and saturation sequences against a behavioural RAM.
module tb_ram_arbiter;
  localparam int AW = 11;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          m0_valid = 1'b0, m1_valid = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [31:0]   m0_wdata = 32'h0, m1_wdata = 32'h0;
  logic [3:0]    m0_wstrb = 4'h0, m1_wstrb = 4'h0;
  logic          m0_ready, m1_ready;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [3:0]    ram_we;
  logic [31:0]   ram_rdata = 32'h0;
  logic          grant;
  logic [CW-1:0] conflicts;

  // Small-counter instance, kept under constant contention
  logic          c_m0_valid = 1'b0, c_m1_valid = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic [31:0]   c_wdata = 32'h0;
  logic [3:0]    c_wstrb = 4'h0;
  logic [31:0]   c_ram_rdata = 32'h0;
  logic          c_m0_ready, c_m1_ready, c_ram_en, c_grant;
  logic [31:0]   c_m0_rdata, c_m1_rdata, c_ram_wdata;
  logic [AW-1:0] c_ram_addr;
  logic [3:0]    c_ram_we;
  logic [3:0]    c_conflicts;

  logic [31:0]   mem [0:2047];
  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int rdy_cnt = 0;
  int en0, rdy0;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(AW), .CW(CW)) u_dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .grant(grant), .conflicts(conflicts)
  );

  ram_arbiter #(.AW(AW), .CW(4)) u_dut4 (
    .clk(clk), .resetn(resetn),
    .m0_valid(c_m0_valid), .m0_addr(c_addr), .m0_wdata(c_wdata), .m0_wstrb(c_wstrb),
    .m0_ready(c_m0_ready), .m0_rdata(c_m0_rdata),
    .m1_valid(c_m1_valid), .m1_addr(c_addr), .m1_wdata(c_wdata), .m1_wstrb(c_wstrb),
    .m1_ready(c_m1_ready), .m1_rdata(c_m1_rdata),
    .ram_en(c_ram_en), .ram_addr(c_ram_addr), .ram_wdata(c_ram_wdata), .ram_we(c_ram_we),
    .ram_rdata(c_ram_rdata), .grant(c_grant), .conflicts(c_conflicts)
  );

  // Synchronous RAM: read-before-write, data one cycle after ram_en
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  // Count RAM strobes and ready pulses over each ending cycle
  always @(posedge clk) begin
    if (ram_en) en_cnt++;
    if (m0_ready || m1_ready) rdy_cnt++;
  end

  typedef struct {
    logic          m;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic [31:0]   exp_rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_m(input logic m, input logic v, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    if (m) begin
      m1_valid = v; m1_addr = a; m1_wdata = d; m1_wstrb = s;
    end else begin
      m0_valid = v; m0_addr = a; m0_wdata = d; m0_wstrb = s;
    end
  endtask

  task automatic check_quiet(input string name);
    check({name, "_en"}, {31'h0, ram_en}, 32'h0);
    check({name, "_we"}, {28'h0, ram_we}, 32'h0);
    check({name, "_addr"}, {21'h0, ram_addr}, 32'h0);
    check({name, "_wdata"}, ram_wdata, 32'h0);
  endtask

  task automatic run_vec(input int i);
    @(negedge clk);
    set_m(vecs[i].m, 1'b1, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
    @(negedge clk);
    check("vec_issue_en", {31'h0, ram_en}, 32'h1);
    check("vec_issue_addr", {21'h0, ram_addr}, {21'h0, vecs[i].addr});
    check("vec_issue_we", {28'h0, ram_we}, {28'h0, vecs[i].wstrb});
    check("vec_issue_wdata", ram_wdata, vecs[i].wdata);
    check("vec_issue_grant", {31'h0, grant}, {31'h0, vecs[i].m});
    check("vec_issue_noready", {30'h0, m1_ready, m0_ready}, 32'h0);
    @(negedge clk);
    check("vec_resp_ready", {30'h0, m1_ready, m0_ready}, vecs[i].m ? 32'h2 : 32'h1);
    check("vec_resp_rdata", vecs[i].m ? m1_rdata : m0_rdata, vecs[i].exp_rdata);
    check("vec_resp_other_rdata", vecs[i].m ? m0_rdata : m1_rdata, 32'h0);
    check_quiet("vec_resp");
    set_m(vecs[i].m, 1'b0, '0, 32'h0, 4'h0);
    @(negedge clk);
    check("vec_idle_ready", {30'h0, m1_ready, m0_ready}, 32'h0);
    check("vec_idle_rdata", m0_rdata | m1_rdata, 32'h0);
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) mem[a] = 32'h0;
    mem[5] = 32'h1234_5678;
    vecs[0] = '{1'b0, 11'h005, 32'h0000_0000, 4'h0, 32'h1234_5678};
    vecs[1] = '{1'b1, 11'h7FF, 32'hA5A5_A5A5, 4'h3, 32'h0000_0000};
    vecs[2] = '{1'b1, 11'h7FF, 32'h0000_0000, 4'h0, 32'h0000_A5A5};
    vecs[3] = '{1'b0, 11'h010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000};
    vecs[4] = '{1'b0, 11'h010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF};
    vecs[5] = '{1'b1, 11'h010, 32'h1122_3344, 4'h8, 32'hDEAD_BEEF};
    vecs[6] = '{1'b0, 11'h010, 32'h0000_0000, 4'h0, 32'h11AD_BEEF};
    vecs[7] = '{1'b1, 11'h005, 32'hFFFF_FFFF, 4'h0, 32'h1234_5678};

    // Reset state
    #2;
    check_quiet("rst");
    check("rst_grant", {31'h0, grant}, 32'h0);
    check("rst_conflicts", {16'h0, conflicts}, 32'h0);
    check("rst_ready", {30'h0, m1_ready, m0_ready}, 32'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i);

    // Continuous contention from reset: 0,1,0,1 with one conflict per grant
    @(negedge clk); resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
    set_m(1'b0, 1'b1, 11'h005, 32'h0, 4'h0);
    set_m(1'b1, 1'b1, 11'h7FF, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("v3_grant", {31'h0, grant}, (k % 2));
      check("v3_en", {31'h0, ram_en}, 32'h1);
      check("v3_addr", {21'h0, ram_addr}, (k % 2) ? 32'h7FF : 32'h005);
      check("v3_conflicts", {16'h0, conflicts}, k + 1);
      @(negedge clk);
      check("v3_ready", {30'h0, m1_ready, m0_ready}, (k % 2) ? 32'h2 : 32'h1);
      check("v3_rdata", (k % 2) ? m1_rdata : m0_rdata, (k % 2) ? 32'h0000_A5A5 : 32'h1234_5678);
    end
    set_m(1'b0, 1'b0, '0, 32'h0, 4'h0);
    set_m(1'b1, 1'b0, '0, 32'h0, 4'h0);
    @(negedge clk);
    check("v3_idle_en", {31'h0, ram_en}, 32'h0);

    // m0 re-requests right after its ready while m1 waits: m1 goes first
    @(negedge clk);
    en0 = en_cnt; rdy0 = rdy_cnt;
    set_m(1'b0, 1'b1, 11'h005, 32'h0, 4'h0);
    @(negedge clk);
    check("v4_grant0", {31'h0, grant}, 32'h0);
    set_m(1'b1, 1'b1, 11'h7FF, 32'h0, 4'h0);
    @(negedge clk);
    check("v4_ready0", {30'h0, m1_ready, m0_ready}, 32'h1);
    set_m(1'b0, 1'b1, 11'h010, 32'h0, 4'h0);
    @(negedge clk);
    check("v4_grant1", {31'h0, grant}, 32'h1);
    check("v4_addr1", {21'h0, ram_addr}, 32'h7FF);
    check("v4_conflicts", {16'h0, conflicts}, 32'd5);
    @(negedge clk);
    check("v4_ready1", {30'h0, m1_ready, m0_ready}, 32'h2);
    set_m(1'b1, 1'b0, '0, 32'h0, 4'h0);
    @(negedge clk);
    check("v4_grant0b", {31'h0, grant}, 32'h0);
    check("v4_addr0b", {21'h0, ram_addr}, 32'h010);
    check("v4_conflicts_b", {16'h0, conflicts}, 32'd5);
    @(negedge clk);
    check("v4_ready0b", {30'h0, m1_ready, m0_ready}, 32'h1);
    check("v4_rdata0b", m0_rdata, 32'h11AD_BEEF);
    set_m(1'b0, 1'b0, '0, 32'h0, 4'h0);
    @(negedge clk);
    check("v4_en_count", en_cnt - en0, 32'd3);
    check("v4_ready_count", rdy_cnt - rdy0, 32'd3);

    // Reset during ISSUE of a write
    @(negedge clk);
    set_m(1'b1, 1'b1, 11'h020, 32'hCAFE_F00D, 4'hF);
    @(negedge clk);
    check("v5_issue_we", {28'h0, ram_we}, 32'hF);
    #2 resetn = 1'b0;
    #1;
    check_quiet("v5_async");
    check("v5_grant", {31'h0, grant}, 32'h0);
    check("v5_conflicts", {16'h0, conflicts}, 32'h0);
    check("v5_ready", {30'h0, m1_ready, m0_ready}, 32'h0);
    set_m(1'b1, 1'b0, '0, 32'h0, 4'h0);
    @(negedge clk);
    check("v5_no_ready", {30'h0, m1_ready, m0_ready}, 32'h0);
    resetn = 1'b1;
    set_m(1'b0, 1'b1, 11'h005, 32'h0, 4'h0);
    set_m(1'b1, 1'b1, 11'h7FF, 32'h0, 4'h0);
    @(negedge clk);
    check("v5_tie_grant", {31'h0, grant}, 32'h0);
    check("v5_tie_addr", {21'h0, ram_addr}, 32'h005);
    check("v5_tie_conflicts", {16'h0, conflicts}, 32'h1);
    @(negedge clk);
    check("v5_ready0", {30'h0, m1_ready, m0_ready}, 32'h1);
    set_m(1'b0, 1'b0, '0, 32'h0, 4'h0);
    @(negedge clk);
    check("v5_grant1", {31'h0, grant}, 32'h1);
    check("v5_conflicts_b", {16'h0, conflicts}, 32'h1);
    @(negedge clk);
    check("v5_ready1", {30'h0, m1_ready, m0_ready}, 32'h2);
    set_m(1'b1, 1'b0, '0, 32'h0, 4'h0);
    @(negedge clk);

    // Granted valid dropped during ISSUE still completes
    @(negedge clk);
    set_m(1'b0, 1'b1, 11'h005, 32'h0, 4'h0);
    @(negedge clk);
    check("drop_issue_en", {31'h0, ram_en}, 32'h1);
    set_m(1'b0, 1'b0, '0, 32'h0, 4'h0);
    @(negedge clk);
    check("drop_ready", {30'h0, m1_ready, m0_ready}, 32'h1);
    check("drop_rdata", m0_rdata, 32'h1234_5678);
    @(negedge clk);
    check("drop_idle_en", {31'h0, ram_en}, 32'h0);

    // 4-bit counter under constant contention saturates and holds
    c_m0_valid = 1'b1;
    c_m1_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("v6_first", {28'h0, c_conflicts}, 32'h1);
    repeat (40) @(negedge clk);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check("v6_saturated", {28'h0, c_conflicts}, 32'hF);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter AW, default 11, word-address width of the shared RAM (2048 words).
REQ-002 Parameter CW, default 16, width of the conflict statistics counter.
REQ-003 clk  in  1  single clock; all state is updated on its rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 m0_valid  in  1  requester 0 (CPU) access request; held until m0_ready.
REQ-006 m0_addr  in  AW  requester 0 word address.
REQ-007 m0_wdata  in  32  requester 0 write data.
REQ-008 m0_wstrb  in  4  requester 0 byte write strobes; 0 means read.
REQ-009 m0_ready  out  1  one-cycle completion pulse to requester 0.
REQ-010 m0_rdata  out  32  requester 0 read data, valid while m0_ready=1.
REQ-011 m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same directions, widths and meanings as m0_*, for requester 1 (DMA/video fetch).
REQ-012 ram_en  out  1  RAM enable.
REQ-013 ram_addr  out  AW  RAM word address.
REQ-014 ram_wdata  out  32  RAM write data.
REQ-015 ram_we  out  4  RAM byte write enables.
REQ-016 ram_rdata  in  32  RAM read data, valid one cycle after ram_en.
REQ-017 grant  out  1  requester currently owning the RAM (0 or 1).
REQ-018 conflicts  out  CW  count of arbitration cycles in which both requesters were valid.

Function
REQ-019 FSM states IDLE, ISSUE, RESP; one transaction occupies exactly one ISSUE and one RESP cycle.
REQ-020 IDLE: if any mN_valid, register grant and go to ISSUE; else stay in IDLE.
REQ-021 Arbitration is round-robin: single valid wins; both valid -> grant the requester not granted last (last_grant register).
REQ-022 ISSUE: ram_en=1; ram_addr, ram_wdata and ram_we equal the granted requester's addr, wdata and wstrb; next state RESP.
REQ-023 Outside ISSUE: ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
REQ-024 RESP: granted mN_ready=1 and mN_rdata=ram_rdata; the other requester's ready=0 and rdata=0.
REQ-025 mN_rdata=0 whenever mN_ready=0.
REQ-026 Latency: valid sampled high in IDLE at cycle T -> ISSUE at T+1 -> ready at T+2.
REQ-027 RESP arbitration ignores the just-served requester (its valid is still high in its ready cycle); if the other is valid -> grant it, go to ISSUE; else go to IDLE.
REQ-028 last_grant updates on every entry to ISSUE.
REQ-029 Writes also pulse ready in RESP; rdata content for writes is don't-care but is still passed through.
REQ-030 Granted valid dropping during ISSUE (protocol violation): the access still completes and ready still pulses.
REQ-031 conflicts increments by 1 in each arbitration cycle (IDLE with both valid, or RESP with the other valid while the served one is still valid); it saturates at all-ones.
REQ-032 No requester waits more than 4 cycles from valid to ISSUE under continuous contention.

Reset
REQ-033 resetn=0 forces IDLE, grant=0, last_grant=1 (requester 0 wins the first tie), conflicts=0, all ready=0, and all ram_* outputs=0, immediately (asynchronously).
REQ-034 Reset mid-transaction abandons it with no ready pulse; a write already issued in ISSUE is not undone.

Verification
V1 Reset, m0 read addr 0x005 with RAM word 5=0x12345678 -> ram_en at T+1 with addr 0x005, m0_ready and m0_rdata=0x12345678 at T+2.
V2 m1 write addr 0x7FF, wdata 0xA5A5A5A5, wstrb 0x3 -> ram_we=0x3 at T+1, m1_ready at T+2; read-back returns 0x0000A5A5 in the low half.
V3 After reset, m0 and m1 valid together and held continuously -> grant sequence 0,1,0,1; ready pulses every 2 cycles; conflicts increments once per grant.
V4 Back-to-back contention: m0 valid again immediately after its ready while m1 is pending -> m1 is served next; no cycle of ram_en=1 goes without a matching ready.
V5 resetn asserted during ISSUE of a write -> all outputs 0 at once, no ready; after release, IDLE and m0 wins the first tie.
V6 Force conflicts to near all-ones with CW=4 and run 20 contention cycles -> holds at 0xF.
